// File: rtl/ifu_pkg.sv
// ifu_pkg: shared CPU widths, IFU reset/NOP defaults, FSM encoding and alignment helper
package ifu_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h8000_0000;
   localparam logic [ILEN-1:0] NOP_INST_DEF = 32'h0000_0013;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;
   function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/ifu_npc.sv
// ifu_npc: next-pc mux selecting aligned redirect target, pc+4 or hold
module ifu_npc
   import ifu_pkg::*;
(
   input  logic [XLEN-1:0] pc_i,
   input  logic            inc_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic [XLEN-1:0] npc_o
);
   always_comb npc_o = redirect_valid_i ? align4(redirect_pc_i) : inc_i ? pc_i + 64'd4 : pc_i;
endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch FSM issuing imem requests and presenting one instruction at a time to decode
module ifu
   import ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [ILEN-1:0] NOP_INST = NOP_INST_DEF
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic [XLEN-1:0] fetch_cnt
);
   state_e          state_q;
   logic [XLEN-1:0] pc_q, pc_d, addr_q, inst_pc_q, cnt_q;
   logic [ILEN-1:0] inst_q;
   logic            drop_q;
   ifu_npc u_npc (
      .pc_i             (pc_q),
      .inc_i            (state_q == OUT && inst_ready),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .npc_o            (pc_d)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         drop_q    <= 1'b0;
         inst_q    <= NOP_INST;
         inst_pc_q <= '0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               pc_q <= pc_d;
               if (!halt) begin
                  state_q <= REQ;
                  addr_q  <= pc_d;
               end
            end
            REQ: begin
               pc_q <= pc_d;
               if (redirect_valid) drop_q <= 1'b1;
               if (imem_req_ready) state_q <= WAIT;
            end
            WAIT: begin
               pc_q <= pc_d;
               if (redirect_valid) drop_q <= 1'b1;
               if (imem_resp_valid) begin
                  if (drop_q || redirect_valid) begin
                     drop_q  <= 1'b0;
                     state_q <= REQ;
                     addr_q  <= pc_d;
                  end else begin
                     inst_q    <= imem_resp_data;
                     inst_pc_q <= pc_q;
                     state_q   <= OUT;
                  end
               end
            end
            OUT: begin
               if (inst_ready || redirect_valid) begin
                  pc_q    <= pc_d;
                  addr_q  <= pc_d;
                  state_q <= (inst_ready && halt) ? IDLE : REQ;
                  if (inst_ready) cnt_q <= cnt_q + 64'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   always_comb begin
      imem_req_valid = state_q == REQ;
      imem_req_addr  = addr_q;
      inst_valid     = state_q == OUT;
      inst           = inst_valid ? inst_q : NOP_INST;
      inst_pc        = inst_pc_q;
      fetch_cnt      = cnt_q;
   end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, 64'h8000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, 32'h0000_0013, value driven on inst when no instruction is held.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  64  fetch address.
REQ-008 imem_resp_valid  input  1  response data valid.
REQ-009 imem_resp_data  input  32  fetched instruction word.
REQ-010 inst  output  32  instruction presented to the decoder.
REQ-011 inst_pc  output  64  address of inst.
REQ-012 inst_valid  output  1  inst/inst_pc valid.
REQ-013 inst_ready  input  1  decoder/execute consumes inst this cycle.
REQ-014 redirect_valid  input  1  branch/jal/jalr taken.
REQ-015 redirect_pc  input  64  redirect target.
REQ-016 halt  input  1  stop fetching (driven by the ebreak flag).
REQ-017 fetch_cnt  output  64  count of instructions consumed.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, OUT; one state per cycle minimum.
REQ-019 IDLE: outputs idle; go to REQ next cycle when halt=0, else stay.
REQ-020 REQ: imem_req_valid=1, imem_req_addr=pc; on valid&&ready go to WAIT.
REQ-021 While imem_req_valid=1 and imem_req_ready=0, imem_req_addr is held stable.
REQ-022 WAIT: on imem_resp_valid, if drop=0 latch inst<=imem_resp_data, inst_pc<=pc, go to OUT; if drop=1 discard data, clear drop, go to REQ.
REQ-023 OUT: inst_valid=1; inst and inst_pc are stable until consumed or flushed.
REQ-024 OUT with inst_ready=1 and redirect_valid=0: pc<=pc+4, fetch_cnt+1, go to REQ (IDLE if halt=1).
REQ-025 OUT with inst_ready=1 and redirect_valid=1: pc<=redirect_pc, fetch_cnt+1, go to REQ (IDLE if halt=1).
REQ-026 OUT with inst_ready=0 and redirect_valid=1: instruction dropped, fetch_cnt unchanged, pc<=redirect_pc, go to REQ.
REQ-027 redirect_valid in REQ (request not yet accepted): address is not changed; pc<=redirect_pc is latched as pending; on handshake go to WAIT with drop=1.
REQ-028 redirect_valid in WAIT: pc<=redirect_pc, drop<=1; when a response arrives in the same cycle it is discarded.
REQ-029 redirect_valid in IDLE: pc<=redirect_pc.
REQ-030 Any pc update from redirect_pc forces bits [1:0] to 0.
REQ-031 pc+4 wraps modulo 2^64; fetch_cnt wraps modulo 2^64.
REQ-032 Latency: first inst_valid appears no earlier than 3 cycles after rst deasserts, given zero-wait memory.
REQ-033 inst=NOP_INST and inst_valid=0 in every state except OUT.
REQ-034 Response in REQ or IDLE (unsolicited) is ignored.

Reset
REQ-035 On rst=1 at a clock edge: state=IDLE, pc=RESET_PC, drop=0, inst=NOP_INST, inst_pc=0, inst_valid=0, imem_req_valid=0, imem_req_addr=RESET_PC, fetch_cnt=0.
REQ-036 rst mid-request or mid-wait abandons the transaction; any response arriving after reset is ignored until a new request is accepted.

Structure
REQ-037 RESET_PC default, NOP_INST, and the FSM state encoding belong in the shared defines header, beside the CPU width macros.
REQ-038 One sub-module, ifu_npc, is the natural split: a combinational next-pc mux (pc+4 / redirect with alignment); the FSM and registers stay in ifu.

Verification
REQ-039 Reset, then zero-wait memory returning 32'h0010_0093 -> imem_req_addr=0x8000_0000, inst_valid in cycle 3, inst_pc=0x8000_0000, next request 0x8000_0004.
REQ-040 imem_req_ready held low 5 cycles -> imem_req_valid stays 1 and address stays stable; exactly one WAIT follows.
REQ-041 OUT, inst_ready=1, redirect_valid=1, redirect_pc=0x8000_0103 -> next request address 0x8000_0100, fetch_cnt+1.
REQ-042 redirect_valid in WAIT to 0x8000_0200, response next cycle -> response discarded, inst_valid stays 0, next request 0x8000_0200.
REQ-043 halt=1 while consuming -> FSM returns to IDLE, no further requests; halt=0 -> fetch resumes at pc+4.
REQ-044 pc=64'hFFFF_FFFF_FFFF_FFFC consumed -> next request 0x0; rst asserted in WAIT -> all outputs return to reset values.
